ai_slave_wr_arbiter: RTL and testbench

//  Per-slave write-path arbiter. Shares one slave's AW and W channels between MST_AMT master-side dispatchers.
//  - AW: round-robin grant, registered through a one-entry output slot.
//  - W: granted master indices are queued in an order FIFO; W bursts are forwarded strictly in AW-grant order.
//  - Sits between the per-master dispatchers' sa_* outputs and one slave port. B/AR/R channels are out of scope.

---
 rtl/ai_slave_wr_arbiter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ai_slave_wr_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_slave_wr_arbiter.sv
// -----------------------------------------------------------------------------
// ai_slave_wr_arbiter
//
// Purpose:
//   Write-path arbiter in front of one slave port. MST_AMT master-side
//   dispatchers compete for the slave's AW channel; the winner is chosen
//   round-robin and its AW payload is registered into a one-entry output slot.
//   Every granted master index is pushed into an order FIFO, and the W channel
//   is steered to the master at the FIFO head, so W bursts reach the slave in
//   exactly the order their AWs were granted. B/AR/R are not handled here.
//
// Handshake semantics (all channels):
//   A transfer happens on a rising ACLK_i edge where VALID and READY are both
//   high. A source holds VALID and its payload stable until that edge. READY
//   may depend combinationally on VALID; VALID never depends on READY.
//
// Ports:
//   ACLK_i, ARESET_i            clock, synchronous active-high reset
//   dsp_AW*_i                   packed AW payloads, master k in slice k
//   dsp_AWVALID_i/AWREADY_o     AW request per master / one-hot grant
//   dsp_WDATA_i/WLAST_i/WVALID_i packed W inputs per master
//   dsp_WREADY_o                W ready, one-hot to the FIFO-head master
//   s_AW*_o, s_AWVALID_o        registered AW to the slave
//   s_AWREADY_i                 AW ready from the slave
//   s_WDATA_o/WLAST_o/WVALID_o  W to the slave (combinational mux)
//   s_WREADY_i                  W ready from the slave
//   outst_full_o                order FIFO holds OUTSTANDING_AMT entries
// -----------------------------------------------------------------------------
module ai_slave_wr_arbiter #(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESET_i,
  // master-side AW
  input  logic [MST_AMT*TRANS_MST_ID_W-1:0]      dsp_AWID_i,
  input  logic [MST_AMT*ADDR_WIDTH-1:0]          dsp_AWADDR_i,
  input  logic [MST_AMT*TRANS_BURST_W-1:0]       dsp_AWBURST_i,
  input  logic [MST_AMT*TRANS_DATA_LEN_W-1:0]    dsp_AWLEN_i,
  input  logic [MST_AMT*TRANS_DATA_SIZE_W-1:0]   dsp_AWSIZE_i,
  input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
  output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
  // master-side W
  input  logic [MST_AMT*DATA_WIDTH-1:0]          dsp_WDATA_i,
  input  logic [MST_AMT-1:0]                     dsp_WLAST_i,
  input  logic [MST_AMT-1:0]                     dsp_WVALID_i,
  output logic [MST_AMT-1:0]                     dsp_WREADY_o,
  // slave-side AW
  output logic [TRANS_MST_ID_W-1:0]              s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
  output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
  output logic                                   s_AWVALID_o,
  input  logic                                   s_AWREADY_i,
  // slave-side W
  output logic [DATA_WIDTH-1:0]                  s_WDATA_o,
  output logic                                   s_WLAST_o,
  output logic                                   s_WVALID_o,
  input  logic                                   s_WREADY_i,
  // status
  output logic                                   outst_full_o
);

  localparam int MIDX_W = (MST_AMT > 1) ? $clog2(MST_AMT) : 1;
  localparam int PTR_W  = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int CNT_W  = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                          aw_valid_q, aw_valid_d;
  logic [TRANS_MST_ID_W-1:0]     aw_id_q,    aw_id_d;
  logic [ADDR_WIDTH-1:0]         aw_addr_q,  aw_addr_d;
  logic [TRANS_BURST_W-1:0]      aw_burst_q, aw_burst_d;
  logic [TRANS_DATA_LEN_W-1:0]   aw_len_q,   aw_len_d;
  logic [TRANS_DATA_SIZE_W-1:0]  aw_size_q,  aw_size_d;

  logic [MIDX_W-1:0]             rr_ptr_q, rr_ptr_d;

  logic [MIDX_W-1:0]             fifo_q [OUTSTANDING_AMT];
  logic [MIDX_W-1:0]             fifo_d [OUTSTANDING_AMT];
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q,  count_d;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  logic              fifo_full;
  logic              fifo_empty;
  logic              slot_free;
  logic              can_grant;
  logic              req_found;
  logic [MIDX_W-1:0] grant_idx;
  logic              grant;
  logic              pop;
  logic [MIDX_W-1:0] head_idx;

  assign fifo_full  = (count_q == CNT_W'(OUTSTANDING_AMT));
  assign fifo_empty = (count_q == '0);
  // The slot can take a new AW if it is empty or is being drained this cycle.
  // Fullness uses the registered count, so a same-cycle pop does not unblock.
  assign slot_free  = !aw_valid_q || s_AWREADY_i;
  assign can_grant  = slot_free && !fifo_full;
  assign grant      = can_grant && req_found;

  // Round robin: first look at masters at or above rr_ptr, then wrap around to
  // the low indices. The first pass has priority over the second.
  always_comb begin
    req_found = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < MST_AMT; k++) begin
      if (!req_found && dsp_AWVALID_i[k] && (MIDX_W'(k) >= rr_ptr_q)) begin
        req_found = 1'b1;
        grant_idx = MIDX_W'(k);
      end
    end
    for (int k = 0; k < MST_AMT; k++) begin
      if (!req_found && dsp_AWVALID_i[k]) begin
        req_found = 1'b1;
        grant_idx = MIDX_W'(k);
      end
    end
  end

  always_comb begin
    dsp_AWREADY_o = '0;
    for (int k = 0; k < MST_AMT; k++) begin
      dsp_AWREADY_o[k] = grant && (grant_idx == MIDX_W'(k));
    end
  end

  // ---------------------------------------------------------------------------
  // AW slot next state
  // ---------------------------------------------------------------------------
  always_comb begin
    aw_valid_d = aw_valid_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_burst_d = aw_burst_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    if (grant) begin
      aw_valid_d = 1'b1;
      for (int k = 0; k < MST_AMT; k++) begin
        if (grant_idx == MIDX_W'(k)) begin
          aw_id_d    = dsp_AWID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
          aw_addr_d  = dsp_AWADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          aw_burst_d = dsp_AWBURST_i[k*TRANS_BURST_W +: TRANS_BURST_W];
          aw_len_d   = dsp_AWLEN_i[k*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
          aw_size_d  = dsp_AWSIZE_i[k*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
        end
      end
    end else if (s_AWREADY_i) begin
      aw_valid_d = 1'b0;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (grant_idx == MIDX_W'(MST_AMT - 1)) ? '0 : grant_idx + MIDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // W steering from the order FIFO head
  // ---------------------------------------------------------------------------
  assign head_idx = fifo_q[rd_ptr_q];

  always_comb begin
    s_WVALID_o   = 1'b0;
    s_WLAST_o    = 1'b0;
    s_WDATA_o    = '0;
    dsp_WREADY_o = '0;
    if (!fifo_empty) begin
      for (int k = 0; k < MST_AMT; k++) begin
        if (head_idx == MIDX_W'(k)) begin
          s_WVALID_o      = dsp_WVALID_i[k];
          s_WLAST_o       = dsp_WLAST_i[k];
          s_WDATA_o       = dsp_WDATA_i[k*DATA_WIDTH +: DATA_WIDTH];
          dsp_WREADY_o[k] = s_WREADY_i;
        end
      end
    end
  end

  // A burst retires on its accepted last beat; beats are not counted.
  assign pop = s_WVALID_o && s_WREADY_i && s_WLAST_o;

  // ---------------------------------------------------------------------------
  // Order FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int e = 0; e < OUTSTANDING_AMT; e++) begin
      fifo_d[e] = fifo_q[e];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (grant) begin
      fifo_d[wr_ptr_q] = grant_idx;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({grant, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      aw_valid_q <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_burst_q <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int e = 0; e < OUTSTANDING_AMT; e++) begin
        fifo_q[e] <= '0;
      end
    end else begin
      aw_valid_q <= aw_valid_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_burst_q <= aw_burst_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int e = 0; e < OUTSTANDING_AMT; e++) begin
        fifo_q[e] <= fifo_d[e];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_AWVALID_o  = aw_valid_q;
  assign s_AWID_o     = aw_id_q;
  assign s_AWADDR_o   = aw_addr_q;
  assign s_AWBURST_o  = aw_burst_q;
  assign s_AWLEN_o    = aw_len_q;
  assign s_AWSIZE_o   = aw_size_q;
  assign outst_full_o = fifo_full;

endmodule

// File: tb/tb_ai_slave_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for ai_slave_wr_arbiter: a table of directed cycles, hand-written
// multi-cycle sequences (AW back-pressure, alternation and full FIFO, reset
// mid-burst) and a randomized phase checked against a queue-based model.
// -----------------------------------------------------------------------------
module tb_ai_slave_wr_arbiter;

  localparam int M   = 2;
  localparam int OA  = 8;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IDW = 5;
  localparam int BW  = 2;
  localparam int LW  = 3;
  localparam int SW  = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT inputs
  logic [M*IDW-1:0] awid;
  logic [M*AW-1:0]  awaddr;
  logic [M*BW-1:0]  awburst;
  logic [M*LW-1:0]  awlen;
  logic [M*SW-1:0]  awsize;
  logic [M-1:0]     awv;
  logic [M*DW-1:0]  wdata;
  logic [M-1:0]     wl;
  logic [M-1:0]     wv;
  logic             s_awready;
  logic             s_wready;

  // DUT outputs
  logic [M-1:0]     dsp_AWREADY_o;
  logic [M-1:0]     dsp_WREADY_o;
  logic [IDW-1:0]   s_AWID_o;
  logic [AW-1:0]    s_AWADDR_o;
  logic [BW-1:0]    s_AWBURST_o;
  logic [LW-1:0]    s_AWLEN_o;
  logic [SW-1:0]    s_AWSIZE_o;
  logic             s_AWVALID_o;
  logic [DW-1:0]    s_WDATA_o;
  logic             s_WLAST_o;
  logic             s_WVALID_o;
  logic             outst_full_o;

  ai_slave_wr_arbiter #(
    .MST_AMT(M), .OUTSTANDING_AMT(OA), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .TRANS_MST_ID_W(IDW), .TRANS_BURST_W(BW), .TRANS_DATA_LEN_W(LW),
    .TRANS_DATA_SIZE_W(SW)
  ) dut (
    .ACLK_i        (clk),
    .ARESET_i      (rst),
    .dsp_AWID_i    (awid),
    .dsp_AWADDR_i  (awaddr),
    .dsp_AWBURST_i (awburst),
    .dsp_AWLEN_i   (awlen),
    .dsp_AWSIZE_i  (awsize),
    .dsp_AWVALID_i (awv),
    .dsp_AWREADY_o (dsp_AWREADY_o),
    .dsp_WDATA_i   (wdata),
    .dsp_WLAST_i   (wl),
    .dsp_WVALID_i  (wv),
    .dsp_WREADY_o  (dsp_WREADY_o),
    .s_AWID_o      (s_AWID_o),
    .s_AWADDR_o    (s_AWADDR_o),
    .s_AWBURST_o   (s_AWBURST_o),
    .s_AWLEN_o     (s_AWLEN_o),
    .s_AWSIZE_o    (s_AWSIZE_o),
    .s_AWVALID_o   (s_AWVALID_o),
    .s_AWREADY_i   (s_awready),
    .s_WDATA_o     (s_WDATA_o),
    .s_WLAST_o     (s_WLAST_o),
    .s_WVALID_o    (s_WVALID_o),
    .s_WREADY_i    (s_wready),
    .outst_full_o  (outst_full_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: ordered list of granted masters, round-robin start index,
  // one AW slot. Scoreboard exp_q holds AW addresses the slave should receive.
  // ---------------------------------------------------------------------------
  int              order_q[$];
  logic [AW-1:0]   exp_q[$];
  int              m_rr;
  bit              m_slot_v;
  logic [IDW-1:0]  m_id;
  logic [AW-1:0]   m_addr;
  logic [BW-1:0]   m_burst;
  logic [LW-1:0]   m_len;
  logic [SW-1:0]   m_size;
  int              m_g;
  bit              m_pop;
  logic [M-1:0]    e_awready, e_wready;
  logic            e_wvalid, e_wlast, e_full;
  logic [DW-1:0]   e_wdata;

  task automatic model_eval();
    bit slot_free;
    int c;
    int h;
    m_g       = -1;
    e_full    = (order_q.size() == OA);
    slot_free = !m_slot_v || s_awready;
    if (slot_free && !e_full) begin
      for (int i = 0; i < M; i++) begin
        c = (m_rr + i) % M;
        if (m_g < 0 && awv[c]) m_g = c;
      end
    end
    e_awready = '0;
    if (m_g >= 0) e_awready[m_g] = 1'b1;
    e_wvalid = 1'b0;
    e_wlast  = 1'b0;
    e_wdata  = '0;
    e_wready = '0;
    if (order_q.size() > 0) begin
      h           = order_q[0];
      e_wvalid    = wv[h];
      e_wlast     = wl[h];
      e_wdata     = wdata[h*DW +: DW];
      e_wready[h] = s_wready;
    end
    m_pop = e_wvalid && s_wready && e_wlast;
  endtask

  task automatic model_commit();
    if (rst) begin
      order_q.delete();
      exp_q.delete();
      m_rr     = 0;
      m_slot_v = 1'b0;
      m_id = '0; m_addr = '0; m_burst = '0; m_len = '0; m_size = '0;
    end else begin
      if (m_pop) void'(order_q.pop_front());
      if (m_g >= 0) begin
        order_q.push_back(m_g);
        m_slot_v = 1'b1;
        m_id     = awid[m_g*IDW +: IDW];
        m_addr   = awaddr[m_g*AW +: AW];
        m_burst  = awburst[m_g*BW +: BW];
        m_len    = awlen[m_g*LW +: LW];
        m_size   = awsize[m_g*SW +: SW];
        m_rr     = (m_g + 1) % M;
        exp_q.push_back(m_addr);
      end else if (s_awready) begin
        m_slot_v = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    logic [AW-1:0] a;
    chk("awready",   dsp_AWREADY_o, e_awready);
    chk("s_awvalid", s_AWVALID_o,   m_slot_v);
    if (m_slot_v) begin
      chk("s_awid",    s_AWID_o,    m_id);
      chk("s_awaddr",  s_AWADDR_o,  m_addr);
      chk("s_awburst", s_AWBURST_o, m_burst);
      chk("s_awlen",   s_AWLEN_o,   m_len);
      chk("s_awsize",  s_AWSIZE_o,  m_size);
    end
    chk("wready",    dsp_WREADY_o,  e_wready);
    chk("s_wvalid",  s_WVALID_o,    e_wvalid);
    chk("s_wlast",   s_WLAST_o,     e_wlast);
    chk("s_wdata",   s_WDATA_o,     e_wdata);
    chk("full",      outst_full_o,  e_full);
    // end-to-end AW order scoreboard
    if (s_AWVALID_o === 1'b1 && s_awready && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL aw_sb actual=addr %0h expected=no AW pending", s_AWADDR_o);
      end else begin
        a = exp_q.pop_front();
        if (s_AWADDR_o !== a) begin
          errors++;
          $display("FAIL aw_sb actual=%0h expected=%0h", s_AWADDR_o, a);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 1 time unit after the rising edge; outputs are
  // sampled 3 units later, well before the next rising edge.
  // ---------------------------------------------------------------------------
  task automatic pre(input bit mcheck);
    #3;
    model_eval();
    if (mcheck) model_check();
  endtask

  task automatic post();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic step(input bit mcheck);
    pre(mcheck);
    post();
  endtask

  task automatic idle_inputs();
    awv = '0; wv = '0; wl = '0;
    s_awready = 1'b1; s_wready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step(0);
    step(0);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         r;
    logic [1:0] awv, wv, wl;
    bit         sar, swr;
    logic [1:0] e_awr;
    bit         e_sawv;
    logic [1:0] e_wr;
    bit         e_swv, e_swl, e_full;
  } vec_t;

  function automatic vec_t mk(input bit r, input logic [1:0] a, input logic [1:0] v,
                              input logic [1:0] l, input bit sar, input bit swr,
                              input logic [1:0] ea, input bit esav, input logic [1:0] ewr,
                              input bit eswv, input bit eswl, input bit ef);
    vec_t t;
    t.r = r; t.awv = a; t.wv = v; t.wl = l; t.sar = sar; t.swr = swr;
    t.e_awr = ea; t.e_sawv = esav; t.e_wr = ewr; t.e_swv = eswv; t.e_swl = eswl; t.e_full = ef;
    return t;
  endfunction

  vec_t tbl[12];

  initial begin
    awid = '0; awaddr = '0; awburst = '0; awlen = '0; awsize = '0; wdata = '0;
    idle_inputs();
    do_reset();

    // M0 single 4-beat burst, then M0/M1 simultaneous with M1 W early.
    //            rst awv    wv     wl    sar swr e_awr e_sawv e_wr  swv swl full
    tbl[0]  = mk(0, 2'b01, 2'b00, 2'b00, 1, 1, 2'b01, 0, 2'b00, 0, 0, 0);
    tbl[1]  = mk(0, 2'b00, 2'b01, 2'b00, 1, 1, 2'b00, 1, 2'b01, 1, 0, 0);
    tbl[2]  = mk(0, 2'b00, 2'b01, 2'b00, 1, 1, 2'b00, 0, 2'b01, 1, 0, 0);
    tbl[3]  = mk(0, 2'b00, 2'b01, 2'b00, 1, 1, 2'b00, 0, 2'b01, 1, 0, 0);
    tbl[4]  = mk(0, 2'b00, 2'b01, 2'b01, 1, 1, 2'b00, 0, 2'b01, 1, 1, 0);
    tbl[5]  = mk(0, 2'b00, 2'b01, 2'b00, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0);
    tbl[6]  = mk(1, 2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0);
    tbl[7]  = mk(0, 2'b11, 2'b10, 2'b00, 1, 1, 2'b01, 0, 2'b00, 0, 0, 0);
    tbl[8]  = mk(0, 2'b10, 2'b10, 2'b00, 1, 1, 2'b10, 1, 2'b01, 0, 0, 0);
    tbl[9]  = mk(0, 2'b00, 2'b11, 2'b01, 1, 1, 2'b00, 1, 2'b01, 1, 1, 0);
    tbl[10] = mk(0, 2'b00, 2'b10, 2'b10, 1, 1, 2'b00, 0, 2'b10, 1, 1, 0);
    tbl[11] = mk(0, 2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0);

    awaddr = {32'h0000_2000, 32'h0000_1000};
    awlen  = {3'd0, 3'd3};
    wdata  = {32'hBBBB_0001, 32'hAAAA_0001};
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].r; awv = tbl[i].awv; wv = tbl[i].wv; wl = tbl[i].wl;
      s_awready = tbl[i].sar; s_wready = tbl[i].swr;
      pre(0);
      chk($sformatf("tbl%0d.awready", i),   dsp_AWREADY_o, tbl[i].e_awr);
      chk($sformatf("tbl%0d.s_awvalid", i), s_AWVALID_o,   tbl[i].e_sawv);
      chk($sformatf("tbl%0d.wready", i),    dsp_WREADY_o,  tbl[i].e_wr);
      chk($sformatf("tbl%0d.s_wvalid", i),  s_WVALID_o,    tbl[i].e_swv);
      chk($sformatf("tbl%0d.s_wlast", i),   s_WLAST_o,     tbl[i].e_swl);
      chk($sformatf("tbl%0d.full", i),      outst_full_o,  tbl[i].e_full);
      if (i == 1) chk("tbl1.s_awlen", s_AWLEN_o, 3);
      post();
    end
    rst = 1'b0;

    // -------- AW back-pressure: slot holds, no grants, resume on release ----
    do_reset();
    awaddr = {32'h0000_B000, 32'h0000_A000};
    awv = 2'b01;
    pre(1); chk("stall.first_grant", dsp_AWREADY_o, 2'b01); post();
    s_awready = 1'b0;
    awaddr = {32'h0000_B000, 32'h0000_A111};
    for (int i = 0; i < 5; i++) begin
      pre(1);
      chk("stall.awready", dsp_AWREADY_o, 2'b00);
      chk("stall.s_awvalid", s_AWVALID_o, 1'b1);
      chk("stall.s_awaddr", s_AWADDR_o, 32'h0000_A000);
      post();
    end
    s_awready = 1'b1;
    pre(1); chk("stall.release_grant", dsp_AWREADY_o, 2'b01); post();
    awv = 2'b00;
    pre(1); chk("stall.new_payload", s_AWADDR_o, 32'h0000_A111); post();

    // -------- alternation and full FIFO ------------------------------------
    do_reset();
    awv = 2'b11;
    for (int i = 0; i < 8; i++) begin
      pre(1);
      chk($sformatf("alt%0d.awready", i), dsp_AWREADY_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      post();
    end
    pre(1);
    chk("full.flag", outst_full_o, 1'b1);
    chk("full.ninth_stalled", dsp_AWREADY_o, 2'b00);
    post();
    wv = 2'b01; wl = 2'b01;
    pre(1);
    chk("full.pop_cycle_no_grant", dsp_AWREADY_o, 2'b00);
    chk("full.pop_beat", s_WVALID_o, 1'b1);
    post();
    wv = 2'b00; wl = 2'b00;
    pre(1);
    chk("full.cleared", outst_full_o, 1'b0);
    chk("full.ninth_granted", dsp_AWREADY_o, 2'b01);
    post();
    awv = 2'b00;
    step(1);

    // -------- reset in the middle of a burst -------------------------------
    do_reset();
    awlen = {3'd0, 3'd3};
    awv = 2'b01;
    step(1);
    awv = 2'b00; wv = 2'b01; wl = 2'b00;
    step(1);
    rst = 1'b1;
    pre(1); chk("midrst.beat2", s_WVALID_o, 1'b1); post();
    rst = 1'b0;
    pre(1);
    chk("midrst.s_awvalid", s_AWVALID_o, 1'b0);
    chk("midrst.s_wvalid", s_WVALID_o, 1'b0);
    chk("midrst.wready", dsp_WREADY_o, 2'b00);
    chk("midrst.full", outst_full_o, 1'b0);
    post();

    // -------- randomized traffic against the model --------------------------
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      awv       = 2'($urandom_range(0, 3));
      wv        = 2'($urandom_range(0, 3));
      wl        = 2'($urandom_range(0, 3));
      s_awready = ($urandom_range(0, 3) != 0);
      s_wready  = ($urandom_range(0, 4) != 0);
      awid      = 10'($urandom);
      awaddr    = {$urandom, $urandom};
      awburst   = 4'($urandom);
      awlen     = 6'($urandom);
      awsize    = 6'($urandom);
      wdata     = {$urandom, $urandom};
      // bursts of AW-only traffic let the FIFO fill up now and then
      if ((i / 100) % 3 == 1) wv = 2'b00;
      step(1);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
